// File: rtl/arm_multicycle_if.sv
// Unified instruction/data memory port between arm_multicycle (master) and RAM/bus decoder (slave).
// req/ready handshake: the master holds req, we, addr and wdata until ready is seen.
interface arm_multicycle_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/arm_multicycle.sv
// Multicycle ARMv4-subset core: one shared ALU, one unified memory port; MUL only when ARM_MC_MUL_EN is defined.
// Zero-wait cycles: B 3, DP/STR 4, LDR 5, cond-fail 2; mem_ready=0 stalls FETCH/MEMREAD/MEMWRITE with the request held.
module arm_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    arm_multicycle_if.master mem,
    output logic             instr_retired,
    output logic [31:0]      pc_dbg
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
`ifdef ARM_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_instr_q, pc_instr_d, instr_q, instr_d;
    logic [31:0] alu_res_q, alu_res_d, data_q, data_d;
    logic [3:0]  nzcv_q, nzcv_d, flags_q, flags_d;
    logic [31:0] rf_q [0:14];
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [3:0]  cond, cmd, rn, rd, rm, rs;
    logic [1:0]  op;
    logic        ibit, sbit, ubit, lbit, is_mul;
    assign cond   = instr_q[31:28];
    assign op     = instr_q[27:26];
    assign ibit   = instr_q[25];
    assign cmd    = instr_q[24:21];
    assign ubit   = instr_q[23];
    assign sbit   = instr_q[20];
    assign lbit   = instr_q[20];
    assign rn     = instr_q[19:16];
    assign rd     = instr_q[15:12];
    assign rs     = instr_q[11:8];
    assign rm     = instr_q[3:0];
    assign is_mul = (op == 2'b00) && !ibit && (cmd == CMD_AND) && (instr_q[7:4] == 4'b1001);

    // MUL keeps its destination in the Rn field and reads Rs/Rm through the two ports
    logic [3:0]  ra_idx, rb_idx, wr_idx;
    logic [31:0] ra_val, rb_val;
    assign ra_idx = is_mul ? rs : rn;
    assign rb_idx = (state_q == S_MEMWRITE) ? rd : rm;
    assign wr_idx = is_mul ? rn : rd;
    assign ra_val = (ra_idx == 4'd15) ? pc_instr_q + 32'd8 : rf_q[ra_idx];
    assign rb_val = (rb_idx == 4'd15) ? pc_instr_q + 32'd8 : rf_q[rb_idx];

`ifdef ARM_MC_MUL_EN
    logic [31:0] mul_res;
    assign mul_res = ra_val * rb_val;
`endif

    logic cond_ok, undef;
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = nzcv_q[2];
            4'h1: cond_ok = !nzcv_q[2];
            4'h2: cond_ok = nzcv_q[1];
            4'h3: cond_ok = !nzcv_q[1];
            4'h4: cond_ok = nzcv_q[3];
            4'h5: cond_ok = !nzcv_q[3];
            4'h6: cond_ok = nzcv_q[0];
            4'h7: cond_ok = !nzcv_q[0];
            4'h8: cond_ok = nzcv_q[1] && !nzcv_q[2];
            4'h9: cond_ok = !nzcv_q[1] || nzcv_q[2];
            4'hA: cond_ok = (nzcv_q[3] == nzcv_q[0]);
            4'hB: cond_ok = (nzcv_q[3] != nzcv_q[0]);
            4'hC: cond_ok = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'hD: cond_ok = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
        undef = 1'b0;
        case (op)
            2'b00: begin
                if (is_mul)
                    undef = !MUL_EN;
                else if (ibit && (instr_q[11:8] != 4'd0))
                    undef = 1'b1;
                else if (!(cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR}))
                    undef = 1'b1;
            end
            2'b01, 2'b10: undef = 1'b0;
            default: undef = 1'b1;
        endcase
        if (cond == 4'hF)
            undef = 1'b1;
    end

    logic [3:0]  alu_cmd, alu_nzcv;
    logic [31:0] alu_b, alu_bx, alu_y;
    logic [32:0] alu_sum;
    logic        alu_sub, alu_arith, alu_v;
    always_comb begin
        alu_cmd = cmd;
        alu_b   = rb_val;
        if (state_q == S_MEMADR) begin
            alu_cmd = ubit ? CMD_ADD : CMD_SUB;
            alu_b   = {20'h0, instr_q[11:0]};
        end else if (state_q == S_EXECUTEI) begin
            alu_b   = {24'h0, instr_q[7:0]};
        end
        alu_sub   = (alu_cmd == CMD_SUB) || (alu_cmd == CMD_CMP);
        alu_bx    = alu_sub ? ~alu_b : alu_b;
        alu_sum   = {1'b0, ra_val} + {1'b0, alu_bx} + {32'h0, alu_sub};
        alu_arith = (alu_cmd != CMD_AND) && (alu_cmd != CMD_ORR);
        case (alu_cmd)
            CMD_AND: alu_y = ra_val & alu_b;
            CMD_ORR: alu_y = ra_val | alu_b;
            default: alu_y = alu_sum[31:0];
        endcase
        alu_v    = (ra_val[31] == alu_bx[31]) && (alu_y[31] != ra_val[31]);
        alu_nzcv = {alu_y[31], (alu_y == 32'h0),
                    alu_arith ? alu_sum[32] : nzcv_q[1],
                    alu_arith ? alu_v : nzcv_q[0]};
    end

    logic        req_c, we_c, retire_c;
    logic [31:0] addr_c, wdata_c;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_instr_d = pc_instr_q;
        instr_d    = instr_q;
        alu_res_d  = alu_res_q;
        data_d     = data_q;
        nzcv_d     = nzcv_q;
        flags_d    = flags_q;
        rf_we      = 1'b0;
        rf_wa      = wr_idx;
        rf_wd      = alu_res_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = 32'h0;
        wdata_c    = 32'h0;
        retire_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem.mem_ready) begin
                    instr_d    = mem.mem_rdata;
                    pc_instr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!cond_ok || undef) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (op == 2'b01)
                    state_d = S_MEMADR;
                else if (op == 2'b10)
                    state_d = S_BRANCH;
                else
                    state_d = ibit ? S_EXECUTEI : S_EXECUTER;
            end
            S_MEMADR: begin
                alu_res_d = alu_y;
                state_d   = lbit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                addr_c = alu_res_q;
                if (mem.mem_ready) begin
                    data_d  = mem.mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                if (wr_idx == 4'd15) pc_d = data_q;
                else begin rf_we = 1'b1; rf_wd = data_q; end
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = alu_res_q;
                wdata_c = rb_val;
                if (mem.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_res_d = alu_y;
                flags_d   = alu_nzcv;
`ifdef ARM_MC_MUL_EN
                if (is_mul) begin
                    alu_res_d = mul_res;
                    flags_d   = {mul_res[31], (mul_res == 32'h0), nzcv_q[1:0]};
                end
`endif
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                if (is_mul || (cmd != CMD_CMP)) begin
                    if (wr_idx == 4'd15) pc_d = alu_res_q;
                    else rf_we = 1'b1;
                end
                if (sbit || (!is_mul && (cmd == CMD_CMP)))
                    nzcv_d = flags_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                pc_d     = pc_instr_q + 32'd8 + {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_instr_q <= RESET_PC;
            instr_q    <= 32'h0;
            alu_res_q  <= 32'h0;
            data_q     <= 32'h0;
            nzcv_q     <= 4'h0;
            flags_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_instr_q <= pc_instr_d;
            instr_q    <= instr_d;
            alu_res_q  <= alu_res_d;
            data_q     <= data_d;
            nzcv_q     <= nzcv_d;
            flags_q    <= flags_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= 32'h0;
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Reset gates the port directly so an in-flight request drops without waiting for a clock
    logic req_g;
    assign req_g          = req_c & reset;
    assign mem.mem_req    = req_g;
    assign mem.mem_we     = we_c & req_g;
    assign mem.mem_addr   = req_g ? {addr_c[ADDR_W-1:2], 2'b00} : '0;
    assign mem.mem_wdata  = (req_g && we_c) ? wdata_c : 32'h0;
    assign instr_retired  = retire_c & reset;
    assign pc_dbg         = (state_q == S_FETCH) ? pc_q : pc_instr_q;
endmodule

// File: tb/tb_arm_multicycle.sv
// Directed bench for arm_multicycle: wait-state memory model, retire-cycle log, hand-computed results.
module tb_arm_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_retired;
    logic [31:0] pc_dbg;
    int          n_cmp = 0;
    int          n_bad = 0;

    arm_multicycle_if #(.ADDR_W(32)) bus();
    arm_multicycle #(.RESET_PC(32'h100), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .mem(bus),
        .instr_retired(instr_retired), .pc_dbg(pc_dbg));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: addresses below 0x100 are data with dwait wait states; program space answers at once
    logic [31:0] mem [0:127];
    int dwait = 3;
    int wcnt  = 0;
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (bus.mem_ready) wcnt = 0;
            if (wcnt >= ((bus.mem_addr < 32'h100) ? dwait : 0)) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[8:2]];
                if (bus.mem_we) mem[bus.mem_addr[8:2]] = bus.mem_wdata;
            end else begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    int          cyc = 0;
    int          ret_cyc[$];
    logic [3:0]  ret_flags[$];
    bit          ret_prev = 1'b0;
    bit          prev_wait = 1'b0;
    logic [64:0] prev_bus;
    int          stab_err = 0;
    int          wait_seen = 0;
    always @(negedge clk) begin
        #1;
        cyc++;
        if (ret_prev) ret_flags.push_back(dut.nzcv_q);
        ret_prev = instr_retired;
        if (instr_retired) ret_cyc.push_back(cyc);
        if (prev_wait && bus.mem_req && ({bus.mem_we, bus.mem_addr, bus.mem_wdata} != prev_bus))
            stab_err++;
        prev_wait = bus.mem_req && !bus.mem_ready;
        if (prev_wait) wait_seen++;
        prev_bus = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
    end

    localparam int NRET = 17;
`ifdef ARM_MC_MUL_EN
    localparam int MUL_CYC = 4;
    localparam logic [31:0] MUL_RES = 32'd25;
`else
    localparam int MUL_CYC = 2;
    localparam logic [31:0] MUL_RES = 32'd0;
`endif
    int exp_cyc [NRET] = '{0, 4, 4, 7, 8, 7, 4, 3, 2, MUL_CYC, 7, 4, 7, 4, 4, 7, 8};

    task automatic wait_retires(input int n, input string tag);
        int k;
        k = 0;
        while (ret_cyc.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, ret_cyc.size() >= n, 1);
    endtask

    initial begin
        int rc;
        bit found;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[32'h2C >> 2] = 32'hAAAA;
        mem[32'h38 >> 2] = 32'h160;
        mem[32'h3C >> 2] = 32'h3333;
        mem[32'h40 >> 2] = 32'hDEAD;
        mem[32'h44 >> 2] = 32'h1111;
        mem[32'h48 >> 2] = 32'h2222;
        mem[32'h100 >> 2] = 32'h0280_1001; // ADDEQ R1,R0,#1 (fails)
        mem[32'h104 >> 2] = 32'hE280_1005; // ADD  R1,R0,#5
        mem[32'h108 >> 2] = 32'hE251_2007; // SUBS R2,R1,#7
        mem[32'h10C >> 2] = 32'hE580_2020; // STR  R2,[R0,#0x20]
        mem[32'h110 >> 2] = 32'hE590_3020; // LDR  R3,[R0,#0x20]
        mem[32'h114 >> 2] = 32'hE580_3024; // STR  R3,[R0,#0x24]
        mem[32'h118 >> 2] = 32'hE351_0005; // CMP  R1,#5
        mem[32'h11C >> 2] = 32'h0A00_0002; // BEQ  +2 words
        for (int a = 32'h120; a <= 32'h128; a += 4) mem[a >> 2] = 32'hE580_1028;
        mem[32'h12C >> 2] = 32'h1A00_0000; // BNE (not taken)
        mem[32'h130 >> 2] = 32'hE004_0191; // MUL  R4,R1,R1
        mem[32'h134 >> 2] = 32'hE580_402C; // STR  R4,[R0,#0x2C]
        mem[32'h138 >> 2] = 32'hE28F_5000; // ADD  R5,R15,#0
        mem[32'h13C >> 2] = 32'hE580_5030; // STR  R5,[R0,#0x30]
        mem[32'h140 >> 2] = 32'hE381_60F0; // ORR  R6,R1,#0xF0
        mem[32'h144 >> 2] = 32'hE206_703C; // AND  R7,R6,#0x3C
        mem[32'h148 >> 2] = 32'hE580_7034; // STR  R7,[R0,#0x34]
        mem[32'h14C >> 2] = 32'hE590_F038; // LDR  PC,[R0,#0x38]
        for (int a = 32'h150; a <= 32'h15C; a += 4) mem[a >> 2] = 32'hE580_103C;
        mem[32'h160 >> 2] = 32'hE590_9020; // LDR  R9,[R0,#0x20]
        mem[32'h164 >> 2] = 32'hEAFF_FFFE; // B    .

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_retired", instr_retired, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("first_req", bus.mem_req, 1);
        check("first_addr", bus.mem_addr, 32'h100);
        repeat (2) @(posedge clk);
        #2 check("condfail_next_addr", bus.mem_addr, 32'h104);

        wait_retires(NRET, "prog1_retires");
        for (int i = 1; i < NRET; i++)
            check($sformatf("cycles_%0d", i),
                  (i < ret_cyc.size()) ? ret_cyc[i] - ret_cyc[i-1] : -1, exp_cyc[i]);
        check("subs_flags", (ret_flags.size() > 2) ? ret_flags[2] : 4'hX, 4'b1000);
        check("cmp_flags", (ret_flags.size() > 6) ? ret_flags[6] : 4'hX, 4'b0110);
        check("str_r2", mem[32'h20 >> 2], 32'hFFFF_FFFE);
        check("ldr_r3", mem[32'h24 >> 2], 32'hFFFF_FFFE);
        check("beq_skip", mem[32'h28 >> 2], 32'h0);
        check("mul_r4", mem[32'h2C >> 2], MUL_RES);
        check("r15_read", mem[32'h30 >> 2], 32'h140);
        check("orr_and", mem[32'h34 >> 2], 32'h34);
        check("ldr_pc_skip", mem[32'h3C >> 2], 32'h3333);

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            #2;
            if (bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h20 && pc_dbg == 32'h160)
                found = 1'b1;
        end
        check("memread_reached", found, 1);
        check("memread_waiting", bus.mem_ready, 0);
        rc = ret_cyc.size();
        reset = 1'b0;
        #1;
        check("mid_rst_req", bus.mem_req, 0);
        check("mid_rst_r1", dut.rf_q[1], 0);
        check("mid_rst_pc", dut.pc_q, 32'h100);
        check("mid_rst_nzcv", dut.nzcv_q, 0);
        check("stable_during_wait", stab_err, 0);
        check("waits_observed", wait_seen > 20, 1);

        mem[32'h100 >> 2] = 32'hE580_1040; // STR   R1,[R0,#0x40]
        mem[32'h104 >> 2] = 32'h0580_9044; // STREQ R9,[R0,#0x44]
        mem[32'h108 >> 2] = 32'hE580_9048; // STR   R9,[R0,#0x48]
        mem[32'h10C >> 2] = 32'hEAFF_FFFE; // B     .
        repeat (3) @(negedge clk);
        check("no_retire_in_reset", ret_cyc.size(), rc);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("restart_addr", bus.mem_addr, 32'h100);
        wait_retires(rc + 3, "prog2_retires");
        repeat (2) @(negedge clk);
        check("r1_cleared", mem[32'h40 >> 2], 32'h0);
        check("flags_cleared", mem[32'h44 >> 2], 32'h1111);
        check("r9_not_loaded", mem[32'h48 >> 2], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arm_multicycle.md
# arm_multicycle

Parametrised multicycle successor to the single-cycle ARM core: same ARMv4 subset (ADD, SUB, AND, ORR, CMP, LDR, STR, B, conditional execution), but one ALU and one unified memory port shared across cycles under a main FSM. The memory port uses a req/ready handshake, so wait-state memories and memory-mapped peripherals can stall the core. Sits as the CPU inside the top-level SoC, between the unified instruction/data RAM and the bus decoder.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, memory address width; PC and addresses truncated to ADDR_W LSBs on mem_addr
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  memory access request, held until mem_ready
- mem_we  output  1  1 = write (STR), 0 = read
- mem_addr  output  ADDR_W  word address (byte address, bits[1:0] always 00)
- mem_wdata  output  32  store data
- mem_rdata  input  32  read data, valid in the cycle mem_ready=1
- mem_ready  input  1  access completes this cycle
- instr_retired  output  1  one-cycle pulse when an instruction completes (including condition-failed)
- pc_dbg  output  32  architectural PC of the instruction being executed

## Operation

- Register file R0–R14, 32-bit, two read ports, one write port. Reading R15 returns fetched-instruction PC + 8.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready latch Instr, PC<=PC+4, go DECODE; else stay.
- DECODE: read operands, evaluate Cond against NZCV. Condition false or undefined encoding -> retire as NOP, go FETCH. Else: op=01 -> MEMADR; op=00 with I=0 -> EXECUTER, I=1 -> EXECUTEI; op=10 -> BRANCH.
- MEMADR: ALU computes Rn ± imm12 (U bit); L=1 -> MEMREAD, L=0 -> MEMWRITE.
- MEMREAD: read request held until mem_ready; latch data -> MEMWB.
- MEMWB: write Rd; Rd=15 writes PC. Retire, -> FETCH.
- MEMWRITE: mem_we=1, mem_wdata=Rd, held until mem_ready; retire, -> FETCH.
- EXECUTER/EXECUTEI: second operand Rm (no shift) or zero-extended imm8 (rot=0 only; nonzero rot treated as undefined in DECODE). -> ALUWB.
- ALUWB: write Rd unless CMP; Rd=15 writes PC. NZCV updated when S=1 (CMP always). C/V from ADD/SUB/CMP only; AND/ORR leave C,V unchanged. Retire, -> FETCH.
- BRANCH: PC <= PC+8 + (sign-extended imm24 << 2); retire, -> FETCH.
- Arithmetic: 32-bit, wraps modulo 2^32; SUB/CMP C = no borrow.

## Timing

- Reset (asserted): state FETCH, PC=RESET_PC, R0–R14=0, NZCV=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_retired=0.
- First cycle after reset release: mem_req=1, mem_addr=RESET_PC.
- Zero-wait (mem_ready tied 1) cycles per instruction: B 3, DP 4, STR 4, LDR 5, condition-failed 2. Each wait cycle adds one cycle to FETCH/MEMREAD/MEMWRITE.
- mem_addr, mem_we, mem_wdata stable while mem_req=1 and mem_ready=0. mem_req=0 in all non-memory states.
- mem_ready while mem_req=0 ignored.
- Reset mid-access: request dropped immediately, no register/flag/PC update, restart at RESET_PC.
- instr_retired asserts in the final state of each instruction, exactly once per instruction.

## Configuration

- ARM_MC_MUL_EN defined: MUL (op=00, cmd=0000, bits[7:4]=1001) supported, Rd = low 32 bits of Rm×Rs, in EXECUTER->ALUWB (4 cycles zero-wait); S=1 updates N,Z only.
- Undefined: that encoding is undefined -> retired as NOP in DECODE; no multiplier synthesised.

## Test plan

- Reset release with RESET_PC=0x100, mem_ready=1 -> mem_addr=0x100 first cycle, 0x104 after 2 cycles if instr at 0x100 fails its condition.
- ADD R1,R0,#5; SUB R2,R1,#7 with S -> R2=0xFFFFFFFE, N=1,Z=0,C=0; instr_retired every 4 cycles.
- STR R2,[R0,#0x20] then LDR R3,[R0,#0x20] with memory inserting 3 wait cycles each -> STR 7 cycles, LDR 8 cycles, R3=0xFFFFFFFE, address/data stable during waits.
- CMP R1,#5; BEQ +2 words -> branch taken to PC+8+8; BNE not taken, retired in 2 cycles.
- Assert reset during MEMREAD wait -> mem_req=0 immediately, registers zero, fetch resumes at RESET_PC.
- With ARM_MC_MUL_EN: MUL R4,R1,R1 (R1=5) -> R4=25; without: same word retires as NOP, R4 unchanged.
